// File: rtl/hydra_pkg.sv
// hydra_pkg: types shared by the port transmitter and the switch side.
// Control word layout and transmit FSM state encoding.
package hydra_pkg;

    localparam int CTRL_LEN_W = 9;

    typedef struct packed {
        logic [CTRL_LEN_W-1:0] len;
        logic [2:0]            prio;
        logic [3:0]            dest;
    } ctrl_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_CTRL,
        ST_DATA,
        ST_EOP,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/hydra_port_tx.sv
// hydra_port_tx: turns one descriptor into a sop / ctrl / payload / eop
// burst toward the switch, honouring per-port pause back-pressure.
module hydra_port_tx
    import hydra_pkg::*;
#(
    parameter int LEN_W   = 9,
    parameter int MIN_GAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             desc_vld,
    output logic             desc_rdy,
    input  logic [3:0]       desc_dest,
    input  logic [2:0]       desc_prio,
    input  logic [LEN_W-1:0] desc_len,
    input  logic [15:0]      desc_seed,
    input  logic             pause,
    output logic             wr_sop,
    output logic             wr_eop,
    output logic             wr_vld,
    output logic [15:0]      wr_data,
    output logic             busy,
    output logic [15:0]      pkt_cnt
);

    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nxt;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] beat_nxt;

    logic [3:0]       lat_dest;
    logic [2:0]       lat_prio;
    logic [LEN_W-1:0] lat_len;
    logic [15:0]      lat_seed;

    logic             sop_nxt;
    logic             eop_nxt;
    logic             vld_nxt;
    logic [15:0]      data_nxt;
    logic [15:0]      cnt_nxt;
    logic             accept;
    ctrl_word_t       ctrl;

    assign desc_rdy = (state == ST_IDLE) && !pause && (gap == '0);
    assign accept   = desc_vld && desc_rdy;

    always_comb begin
        ctrl      = '0;
        ctrl.len  = CTRL_LEN_W'(lat_len);
        ctrl.prio = lat_prio;
        ctrl.dest = lat_dest;
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        beat_nxt  = beat;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        data_nxt  = wr_data;
        cnt_nxt   = pkt_cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    sop_nxt   = 1'b1;
                    state_nxt = ST_SOP;
                end
            end
            ST_SOP: begin
                state_nxt = ST_CTRL;
                if (!pause) begin
                    vld_nxt  = 1'b1;
                    data_nxt = ctrl;
                end
            end
            ST_CTRL: begin
                // wr_vld high here means the control word is on the bus now
                if (wr_vld) begin
                    beat_nxt = '0;
                    if (lat_len == '0) begin
                        eop_nxt   = 1'b1;
                        state_nxt = ST_EOP;
                    end else begin
                        state_nxt = ST_DATA;
                        if (!pause) begin
                            vld_nxt  = 1'b1;
                            data_nxt = lat_seed;
                            beat_nxt = LEN_W'(1);
                        end
                    end
                end else if (!pause) begin
                    vld_nxt  = 1'b1;
                    data_nxt = ctrl;
                end
            end
            ST_DATA: begin
                // beat counts words already launched; eop ignores pause
                if (beat == lat_len) begin
                    eop_nxt   = 1'b1;
                    state_nxt = ST_EOP;
                end else if (!pause) begin
                    vld_nxt  = 1'b1;
                    data_nxt = lat_seed + 16'(beat);
                    beat_nxt = beat + LEN_W'(1);
                end
            end
            ST_EOP: begin
                cnt_nxt = pkt_cnt + 16'd1;
                if (MIN_GAP > 0) begin
                    gap_nxt   = GAP_W'(MIN_GAP);
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_nxt = gap - GAP_W'(1);
                if (gap <= GAP_W'(1)) begin
                    gap_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gap      <= '0;
            beat     <= '0;
            wr_sop   <= 1'b0;
            wr_eop   <= 1'b0;
            wr_vld   <= 1'b0;
            wr_data  <= '0;
            busy     <= 1'b0;
            pkt_cnt  <= '0;
            lat_dest <= '0;
            lat_prio <= '0;
            lat_len  <= '0;
            lat_seed <= '0;
        end else begin
            state   <= state_nxt;
            gap     <= gap_nxt;
            beat    <= beat_nxt;
            wr_sop  <= sop_nxt;
            wr_eop  <= eop_nxt;
            wr_vld  <= vld_nxt;
            wr_data <= data_nxt;
            busy    <= (state_nxt != ST_IDLE);
            pkt_cnt <= cnt_nxt;
            if (accept) begin
                lat_dest <= desc_dest;
                lat_prio <= desc_prio;
                lat_len  <= desc_len;
                lat_seed <= desc_seed;
            end
        end
    end

endmodule

// File: tb/tb_hydra_port_tx.sv
// tb_hydra_port_tx: directed scenarios for hydra_port_tx with MIN_GAP=2.
// Expected bus cycles are encoded as {sop,eop,vld,data}.
module tb_hydra_port_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_vld;
    logic        desc_rdy;
    logic [3:0]  desc_dest;
    logic [2:0]  desc_prio;
    logic [8:0]  desc_len;
    logic [15:0] desc_seed;
    logic        pause;
    logic        wr_sop;
    logic        wr_eop;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        busy;
    logic [15:0] pkt_cnt;

    integer n_chk = 0;
    integer n_fail = 0;

    localparam logic [18:0] S = 19'h40000;
    localparam logic [18:0] E = 19'h20000;
    localparam logic [18:0] V = 19'h10000;
    localparam logic [18:0] Z = 19'h00000;

    hydra_port_tx #(.LEN_W(9), .MIN_GAP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .desc_vld  (desc_vld),
        .desc_rdy  (desc_rdy),
        .desc_dest (desc_dest),
        .desc_prio (desc_prio),
        .desc_len  (desc_len),
        .desc_seed (desc_seed),
        .pause     (pause),
        .wr_sop    (wr_sop),
        .wr_eop    (wr_eop),
        .wr_vld    (wr_vld),
        .wr_data   (wr_data),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Waits for desc_rdy, offers one descriptor, returns in the sop cycle.
    task automatic offer(input logic [3:0] d, input logic [2:0] p,
                         input logic [8:0] l, input logic [15:0] s,
                         input bit hold);
        bit ok = 1'b0;
        for (int k = 0; k < 32 && !ok; k++) begin
            @(negedge clk);
            if (desc_rdy === 1'b1) begin
                desc_dest = d;
                desc_prio = p;
                desc_len  = l;
                desc_seed = s;
                desc_vld  = 1'b1;
                ok = 1'b1;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL offer timeout: desc_rdy=%b required 1", desc_rdy);
        end
        @(negedge clk);
        if (!hold) desc_vld = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if ({wr_sop, wr_eop, wr_vld, busy} !== 4'b0 || wr_data !== 16'h0 ||
            pkt_cnt !== 16'h0 || desc_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: sop/eop/vld/busy=%b%b%b%b data=%h cnt=%h rdy=%b required 0000 0000 0000 1",
                     wr_sop, wr_eop, wr_vld, busy, wr_data, pkt_cnt, desc_rdy);
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({wr_sop, wr_eop, wr_vld, busy} !== 4'b0 || pkt_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset hold: flags=%b%b%b%b cnt=%h required 0",
                     wr_sop, wr_eop, wr_vld, busy, pkt_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [18:0] exp [7];
        exp = '{S, V | 19'h0243, V | 19'h0100, V | 19'h0101,
                V | 19'h0102, V | 19'h0103, E};
        offer(4'd3, 3'd4, 9'd4, 16'h0100, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0]) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic cyc %0d: got %b%b%b %h busy %b required %h busy 1",
                         i, wr_sop, wr_eop, wr_vld, wr_data, busy, exp[i]);
            end
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL basic pkt_cnt: got %0d required 1", pkt_cnt);
        end
    endtask

    task automatic test_pause();
        logic [18:0] exp [9];
        exp = '{S, V | 19'h0243, V | 19'h0100, V | 19'h0101, Z, Z,
                V | 19'h0102, V | 19'h0103, E};
        offer(4'd3, 3'd4, 9'd4, 16'h0100, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL pause cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
            if (i == 4 || i == 5) begin
                n_chk++;
                if (wr_data !== 16'h0101) begin
                    n_fail++;
                    $display("FAIL pause hold cyc %0d: data %h required 0101", i, wr_data);
                end
            end
            if (i >= 2 && i <= 7) begin
                n_chk++;
                if (desc_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy offer cyc %0d: desc_rdy %b required 0", i, desc_rdy);
                end
            end
            if (i == 1) begin
                desc_dest = 4'hF;
                desc_prio = 3'd7;
                desc_len  = 9'd1;
                desc_seed = 16'hDEAD;
                desc_vld  = 1'b1;
            end
            if (i == 3) pause = 1'b1;
            if (i == 5) pause = 1'b0;
            if (i == 7) desc_vld = 1'b0;
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL pause pkt_cnt: got %0d required 2", pkt_cnt);
        end
    endtask

    task automatic test_pause_eop();
        logic [18:0] exp [5];
        exp = '{S, Z, V | 19'h00A1, V | 19'h0300, E};
        offer(4'd1, 3'd2, 9'd1, 16'h0300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL pause_eop cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
            if (i == 0) pause = 1'b1;
            if (i == 1) pause = 1'b0;
            if (i == 3) pause = 1'b1;
            if (i == 4) pause = 1'b0;
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd3 || wr_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_eop end: cnt %0d vld %b required 3 0", pkt_cnt, wr_vld);
        end
    endtask

    task automatic test_len0();
        logic [18:0] exp [3];
        exp = '{S, V | 19'h0075, E};
        offer(4'd5, 3'd7, 9'd0, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL len0 cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL len0 pkt_cnt: got %0d required 4", pkt_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [18:0] exp [6];
        exp = '{S, V | 19'h0180, V | 19'hFFFE, V | 19'hFFFF, V | 19'h0000, E};
        offer(4'd0, 3'd0, 9'd3, 16'hFFFE, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL wrap cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL wrap pkt_cnt: got %0d required 5", pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp [10];
        exp = '{S, V | 19'h0012, E, Z, Z, Z, S, V | 19'h00B6, V | 19'h0AAA, E};
        offer(4'd2, 3'd1, 9'd0, 16'h5555, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
            if (i >= 3 && i <= 5) begin
                n_chk++;
                if (desc_rdy !== (i == 5)) begin
                    n_fail++;
                    $display("FAIL b2b rdy cyc %0d: got %b required %b", i, desc_rdy, i == 5);
                end
            end
            if (i == 0) begin
                desc_dest = 4'd6;
                desc_prio = 3'd3;
                desc_len  = 9'd1;
                desc_seed = 16'h0AAA;
            end
            if (i == 6) desc_vld = 1'b0;
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL b2b pkt_cnt: got %0d required 7", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] exp [4];
        exp = '{S, V | 19'h0243, V | 19'h0500, V | 19'h0501};
        offer(4'd3, 3'd4, 9'd4, 16'h0500, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL rst_mid cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({wr_sop, wr_eop, wr_vld, busy} !== 4'b0 || wr_data !== 16'h0 ||
            pkt_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid async: flags=%b%b%b%b data=%h cnt=%h required 0",
                     wr_sop, wr_eop, wr_vld, busy, wr_data, pkt_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (wr_eop !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid held cyc %0d: eop %b busy %b required 0 0", i, wr_eop, busy);
            end
        end
        rst_n = 1'b1;
        exp = '{S, V | 19'h0091, V | 19'h0777, E};
        offer(4'd1, 3'd1, 9'd1, 16'h0777, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if ({wr_sop, wr_eop, wr_vld} !== exp[i][18:16] ||
                (exp[i][16] && wr_data !== exp[i][15:0])) begin
                n_fail++;
                $display("FAIL rst_fresh cyc %0d: got %b%b%b %h required %h",
                         i, wr_sop, wr_eop, wr_vld, wr_data, exp[i]);
            end
        end
        @(negedge clk);
        n_chk++;
        if (pkt_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_fresh pkt_cnt: got %0d required 1", pkt_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        desc_vld  = 1'b0;
        desc_dest = '0;
        desc_prio = '0;
        desc_len  = '0;
        desc_seed = '0;
        pause     = 1'b0;
        test_reset();
        test_basic();
        test_pause();
        test_pause_eop();
        test_len0();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
